rgb2yuv_stream: RTL and testbench
=================================

Name: rgb2yuv_stream

Overview:
- RGB-to-YUV 4:2:2 serializer; the reverse direction of the CTE YUV-to-RGB path.
- Accepts one 24-bit RGB pixel per handshake.
- Converts each pixel with a fixed-point colour matrix.
- Emits a byte stream in U0 Y0 V0 Y1 order per pixel pair, i.e. the same byte format the CTE YUV input consumes.
- Sits in front of the CTE op_mode=1 path and in the YUV pattern generator used for loopback checks.

Parameters:
- ROUND_EN, 1: add 128 before the >>8 when 1; pure truncation when 0.
- CLAMP_EN, 1: saturate results to 0..255 when 1; wrap to the low 8 bits when 0.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-low reset (asserted when 0).
- in_en  in  1  rgb_in is valid this cycle.
- rgb_in  in  24  R[23:16], G[15:8], B[7:0], unsigned.
- busy  out  1  when 1, rgb_in is not accepted this cycle.
- out_valid  out  1  yuv_out holds a valid byte.
- yuv_out  out  8  serialized Y/U/V byte.

Behaviour:
- Reset values (on the rising edge with reset=0): busy=0, out_valid=0, yuv_out=8'h00. Input FSM goes to EVEN, byte counter to 0, all pipeline registers to 0, any partial pair is discarded. Reset applied mid-stream discards everything, with no further output.
- Accept rule: a pixel is captured on a rising edge when in_en=1 and busy=0.
- Pixel order: the first accepted pixel after reset is even; pixels alternate even/odd thereafter.
- Arithmetic, all signed, at least 18-bit intermediates, >>> is floor:
  - Y = (77R + 150G + 29B + rnd) >>> 8
  - U = ((-43R - 85G + 128B + rnd) >>> 8) + 128
  - V = ((128R - 107G - 21B + rnd) >>> 8) + 128
  - rnd = 128 if ROUND_EN, else 0.
- Clamping: CLAMP_EN clamps each result to [0,255].
- Chroma subsampling: U and V come from the even pixel only; the odd pixel contributes only Y1.
- Input FSM (registered busy):
  - EVEN (busy=0): accept -> store Y0/U0/V0 one cycle later -> WAIT_ODD.
  - WAIT_ODD (busy=0): stays indefinitely while in_en=0. Accept -> HOLD1, busy=1.
  - HOLD1 (busy=1) -> HOLD2 (busy=1) -> EVEN (busy=0).
  - in_en while busy=1 is ignored; no pixel is consumed.
- Output timing: if the odd pixel is accepted at edge t, the bytes are registered as follows.
  - U0 at edge t+1
  - Y0 at edge t+2
  - V0 at edge t+3
  - Y1 at edge t+4
  - out_valid=1 for exactly those four cycles.
- Sustained rate: the next even pixel is accepted at edge t+3 at the earliest, and its odd pixel at t+4. Its U0 then appears at t+5, giving gap-free output at 1 byte/cycle and 2 pixels per 4 cycles.
- Between pairs: when no pair is pending, out_valid=0 and yuv_out holds its last value.
- Unpaired even pixel: never emits anything until its odd partner arrives.
- Odd-pixel conversion is registered at edge t+1. The even-result registers may be overwritten by the next pair at edge t+4 only after V0 has been registered.

Decomposition:
- Shared package cte_pkg: Q8 coefficient constants, CHROMA_OFS=128, and the byte-slot enum (SLOT_U, SLOT_Y0, SLOT_V, SLOT_Y1).
- Input FSM state enum: kept local to this block.
- One natural sub-module, rgb2yuv_mat: a one-cycle registered matrix producing Y, U and V with rounding and clamping. It is instantiated once, with its select chosen by even/odd phase.

Test Plan:
- White then black: FFFFFF then 000000 -> bytes 80, FF, 80, 00.
- Primary colours: FF0000 (even) then 0000FF (odd) -> 55, 4D, FF, 1D. This checks V saturation at 256 and floor of negative U.
- Green pair: 00FF00 twice -> 2B, 95, 15, 95.
- Back-to-back stream, in_en held 1 for 500 pairs:
  - busy pattern 0,0,1,1 repeating;
  - out_valid continuously 1 after the first U0;
  - 2000 bytes matching the reference model.
- Gapped input: even accepted, then in_en=0 for 10 cycles, then odd -> no out_valid during the gap; U0 appears 1 cycle after the odd accept.
- Reset mid-pair: reset=0 for one cycle between Y0 and V0 -> out_valid=0 next cycle with no further bytes. The next pixel is treated as even and produces a clean 4-byte group.

Source files
------------

// File: rtl/cte_pkg.sv
`default_nettype none
// ============================================================================
// cte_pkg : Q8 colour-matrix constants, chroma offset and YUV byte-slot order
// Rev 1.0
// ============================================================================
package cte_pkg;

  localparam int CALC_W = 19;

  localparam logic signed [CALC_W-1:0] C_YR = 19'sd77;
  localparam logic signed [CALC_W-1:0] C_YG = 19'sd150;
  localparam logic signed [CALC_W-1:0] C_YB = 19'sd29;
  localparam logic signed [CALC_W-1:0] C_UR = -19'sd43;
  localparam logic signed [CALC_W-1:0] C_UG = -19'sd85;
  localparam logic signed [CALC_W-1:0] C_UB = 19'sd128;
  localparam logic signed [CALC_W-1:0] C_VR = 19'sd128;
  localparam logic signed [CALC_W-1:0] C_VG = -19'sd107;
  localparam logic signed [CALC_W-1:0] C_VB = -19'sd21;

  localparam logic signed [CALC_W-1:0] CHROMA_OFS = 19'sd128;
  localparam logic signed [CALC_W-1:0] RND_HALF   = 19'sd128;

  typedef enum logic [1:0] {
    SLOT_U  = 2'd0,
    SLOT_Y0 = 2'd1,
    SLOT_V  = 2'd2,
    SLOT_Y1 = 2'd3
  } slot_e;

  function automatic logic [7:0] sat8(input logic signed [CALC_W-1:0] x,
                                      input logic clamp_en);
    logic [7:0] res;
    if (!clamp_en) begin
      res = x[7:0];
    end else if (x < 19'sd0) begin
      res = 8'd0;
    end else if (x > 19'sd255) begin
      res = 8'd255;
    end else begin
      res = x[7:0];
    end
    return res;
  endfunction

  function automatic slot_e slot_next(input slot_e s);
    slot_e n;
    case (s)
      SLOT_U:  n = SLOT_Y0;
      SLOT_Y0: n = SLOT_V;
      SLOT_V:  n = SLOT_Y1;
      default: n = SLOT_U;
    endcase
    return n;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rgb2yuv_mat.sv
`default_nettype none
// ============================================================================
// rgb2yuv_mat : one-cycle registered RGB->YUV matrix with even (Y0/U0/V0)
//               and odd (Y1) result banks selected by pixel phase
// Rev 1.0
// ============================================================================
module rgb2yuv_mat
  import cte_pkg::*;
#(
  parameter bit ROUND_EN = 1'b1,
  parameter bit CLAMP_EN = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic        sel_odd,
  input  logic [23:0] rgb,
  output logic [7:0]  y0,
  output logic [7:0]  u0,
  output logic [7:0]  v0,
  output logic [7:0]  y1
);

  logic signed [CALC_W-1:0] r_s, g_s, b_s, rnd;
  logic signed [CALC_W-1:0] sum_y, sum_u, sum_v;
  logic signed [CALC_W-1:0] y_s, u_s, v_s;

  logic [7:0] y0_d, u0_d, v0_d, y1_d;
  logic [7:0] y0_q, u0_q, v0_q, y1_q;

  always_comb begin
    r_s   = $signed({11'd0, rgb[23:16]});
    g_s   = $signed({11'd0, rgb[15:8]});
    b_s   = $signed({11'd0, rgb[7:0]});
    rnd   = ROUND_EN ? RND_HALF : 19'sd0;

    sum_y = C_YR * r_s + C_YG * g_s + C_YB * b_s + rnd;
    sum_u = C_UR * r_s + C_UG * g_s + C_UB * b_s + rnd;
    sum_v = C_VR * r_s + C_VG * g_s + C_VB * b_s + rnd;

    // Arithmetic shift gives floor division for negative chroma sums.
    y_s   = sum_y >>> 8;
    u_s   = (sum_u >>> 8) + CHROMA_OFS;
    v_s   = (sum_v >>> 8) + CHROMA_OFS;
  end

  always_comb begin
    y0_d = y0_q;
    u0_d = u0_q;
    v0_d = v0_q;
    y1_d = y1_q;
    if (en) begin
      if (sel_odd) begin
        y1_d = sat8(y_s, CLAMP_EN);
      end else begin
        y0_d = sat8(y_s, CLAMP_EN);
        u0_d = sat8(u_s, CLAMP_EN);
        v0_d = sat8(v_s, CLAMP_EN);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      y0_q <= 8'd0;
      u0_q <= 8'd0;
      v0_q <= 8'd0;
      y1_q <= 8'd0;
    end else begin
      y0_q <= y0_d;
      u0_q <= u0_d;
      v0_q <= v0_d;
      y1_q <= y1_d;
    end
  end

  assign y0 = y0_q;
  assign u0 = u0_q;
  assign v0 = v0_q;
  assign y1 = y1_q;

endmodule
`default_nettype wire

// File: rtl/rgb2yuv_stream.sv
`default_nettype none
// ============================================================================
// rgb2yuv_stream : RGB pixel stream to YUV 4:2:2 byte stream (U0 Y0 V0 Y1)
// Rev 1.0
// ============================================================================
module rgb2yuv_stream
  import cte_pkg::*;
#(
  parameter bit ROUND_EN = 1'b1,
  parameter bit CLAMP_EN = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_en,
  input  logic [23:0] rgb_in,
  output logic        busy,
  output logic        out_valid,
  output logic [7:0]  yuv_out
);

  localparam logic [1:0] ST_EVEN     = 2'd0;
  localparam logic [1:0] ST_WAIT_ODD = 2'd1;
  localparam logic [1:0] ST_HOLD1    = 2'd2;
  localparam logic [1:0] ST_HOLD2    = 2'd3;

  logic [1:0]  state_q, state_d;
  logic        busy_q, busy_d;
  logic        accept, odd_accept;

  logic [23:0] pix_q, pix_d;
  logic        cvt_en_q, cvt_en_d;
  logic        cvt_odd_q, cvt_odd_d;

  logic        run_q, run_d;
  slot_e       slot_q, slot_d;
  logic        out_valid_q, out_valid_d;
  logic [7:0]  yuv_q, yuv_d;
  logic [7:0]  slot_byte;

  logic [7:0]  mat_y0, mat_u0, mat_v0, mat_y1;

  assign accept     = in_en && !busy_q;
  assign odd_accept = accept && (state_q == ST_WAIT_ODD);

  // Input FSM: state register
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ST_EVEN;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
    end
  end

  // Input FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_EVEN:     if (accept) state_d = ST_WAIT_ODD;
      ST_WAIT_ODD: if (accept) state_d = ST_HOLD1;
      ST_HOLD1:    state_d = ST_HOLD2;
      default:     state_d = ST_EVEN;
    endcase
  end

  // Input FSM: outputs, registered so busy is glitch-free at the port
  always_comb begin
    busy_d = (state_d == ST_HOLD1) || (state_d == ST_HOLD2);
  end

  always_comb begin
    pix_d     = accept ? rgb_in : pix_q;
    cvt_en_d  = accept;
    cvt_odd_d = (state_q == ST_WAIT_ODD);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      pix_q     <= 24'd0;
      cvt_en_q  <= 1'b0;
      cvt_odd_q <= 1'b0;
    end else begin
      pix_q     <= pix_d;
      cvt_en_q  <= cvt_en_d;
      cvt_odd_q <= cvt_odd_d;
    end
  end

  rgb2yuv_mat #(
    .ROUND_EN (ROUND_EN),
    .CLAMP_EN (CLAMP_EN)
  ) u_mat (
    .clk     (clk),
    .reset   (reset),
    .en      (cvt_en_q),
    .sel_odd (cvt_odd_q),
    .rgb     (pix_q),
    .y0      (mat_y0),
    .u0      (mat_u0),
    .v0      (mat_v0),
    .y1      (mat_y1)
  );

  always_comb begin
    case (slot_q)
      SLOT_U:  slot_byte = mat_u0;
      SLOT_Y0: slot_byte = mat_y0;
      SLOT_V:  slot_byte = mat_v0;
      default: slot_byte = mat_y1;
    endcase
  end

  // A new odd accept can coincide with the Y1 slot; it restarts at U.
  always_comb begin
    run_d       = run_q;
    slot_d      = slot_q;
    out_valid_d = run_q;
    yuv_d       = run_q ? slot_byte : yuv_q;
    if (odd_accept) begin
      run_d  = 1'b1;
      slot_d = SLOT_U;
    end else if (run_q) begin
      if (slot_q == SLOT_Y1) begin
        run_d = 1'b0;
      end else begin
        slot_d = slot_next(slot_q);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      run_q       <= 1'b0;
      slot_q      <= SLOT_U;
      out_valid_q <= 1'b0;
      yuv_q       <= 8'd0;
    end else begin
      run_q       <= run_d;
      slot_q      <= slot_d;
      out_valid_q <= out_valid_d;
      yuv_q       <= yuv_d;
    end
  end

  assign busy      = busy_q;
  assign out_valid = out_valid_q;
  assign yuv_out   = yuv_q;

endmodule
`default_nettype wire

// File: tb/tb_rgb2yuv_stream.sv
`default_nettype none
// ============================================================================
// tb_rgb2yuv_stream : scoreboard bench for the RGB->YUV 4:2:2 serializer
// Rev 1.0
// ============================================================================
module tb_rgb2yuv_stream;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        in_en = 1'b0;
  logic [23:0] rgb_in = 24'd0;
  logic        busy;
  logic        out_valid;
  logic [7:0]  yuv_out;

  int          total;
  int          bad;
  int          m_st;
  logic [23:0] m_even;
  logic [7:0]  sb[$];

  rgb2yuv_stream #(
    .ROUND_EN (1'b1),
    .CLAMP_EN (1'b1)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .in_en     (in_en),
    .rgb_in    (rgb_in),
    .busy      (busy),
    .out_valid (out_valid),
    .yuv_out   (yuv_out)
  );

  always #5 clk = ~clk;

  function automatic int fl256(input int s);
    int q;
    q = s / 256;
    if ((s % 256) != 0 && s < 0) q = q - 1;
    return q;
  endfunction

  function automatic logic [7:0] sat(input int x);
    int t;
    t = x;
    if (t < 0) t = 0;
    if (t > 255) t = 255;
    return t[7:0];
  endfunction

  function automatic logic m_busy();
    return (m_st == 2) || (m_st == 3);
  endfunction

  task automatic model_pair(input logic [23:0] e, input logic [23:0] o);
    int r, g, b;
    r = int'(e[23:16]); g = int'(e[15:8]); b = int'(e[7:0]);
    sb.push_back(sat(fl256(-43*r - 85*g + 128*b + 128) + 128));
    sb.push_back(sat(fl256(77*r + 150*g + 29*b + 128)));
    sb.push_back(sat(fl256(128*r - 107*g - 21*b + 128) + 128));
    r = int'(o[23:16]); g = int'(o[15:8]); b = int'(o[7:0]);
    sb.push_back(sat(fl256(77*r + 150*g + 29*b + 128)));
  endtask

  // One clock: drive inputs, advance the reference model after the edge.
  task automatic px(input logic en, input logic [23:0] p);
    logic acc;
    in_en  = en;
    rgb_in = p;
    acc    = en && (m_st == 0 || m_st == 1);
    @(posedge clk);
    #1;
    case (m_st)
      0: if (acc) begin m_even = p; m_st = 1; end
      1: if (acc) begin model_pair(m_even, p); m_st = 2; end
      2: m_st = 3;
      default: m_st = 0;
    endcase
    @(negedge clk);
  endtask

  task automatic apply_reset(input int n);
    reset = 1'b0;
    in_en = 1'b0;
    repeat (n) @(posedge clk);
    #1;
    sb.delete();
    m_st  = 0;
    reset = 1'b1;
    @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (reset && out_valid === 1'b1) begin
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL sb_unexpected yuv_out=%h with no byte expected", yuv_out);
      end else begin
        logic [7:0] exp_b;
        exp_b = sb.pop_front();
        if (yuv_out !== exp_b) begin
          bad++;
          $display("FAIL sb_byte got=%h exp=%h t=%0t", yuv_out, exp_b, $time);
        end
      end
    end
  end

  task automatic test_reset();
    apply_reset(3);
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
    total++;
    if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
    total++;
    if (yuv_out !== 8'h00) begin bad++; $display("FAIL reset_yuv got=%h exp=00", yuv_out); end
  endtask

  task automatic test_pair(input string name, input logic [23:0] e,
                           input logic [23:0] o, input logic [31:0] exp_w);
    logic [7:0] exp_b;
    px(1'b1, e);
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL %s_busy_even got=%b exp=0", name, busy); end
    px(1'b1, o);
    total++;
    if (busy !== 1'b1) begin bad++; $display("FAIL %s_busy_odd got=%b exp=1", name, busy); end
    for (int k = 0; k < 4; k++) begin
      px(1'b0, 24'd0);
      exp_b = exp_w[31-8*k -: 8];
      total++;
      if (out_valid !== 1'b1 || yuv_out !== exp_b) begin
        bad++;
        $display("FAIL %s_byte%0d got=%b/%h exp=1/%h", name, k, out_valid, yuv_out, exp_b);
      end
    end
    px(1'b0, 24'd0);
    exp_b = exp_w[7:0];
    total++;
    if (out_valid !== 1'b0 || yuv_out !== exp_b) begin
      bad++;
      $display("FAIL %s_hold got=%b/%h exp=0/%h", name, out_valid, yuv_out, exp_b);
    end
  endtask

  task automatic test_gapped();
    logic gap_ok;
    px(1'b1, 24'hFF0000);
    gap_ok = 1'b1;
    for (int k = 0; k < 10; k++) begin
      px(1'b0, 24'h123456);
      if (out_valid !== 1'b0 || busy !== 1'b0) gap_ok = 1'b0;
    end
    total++;
    if (!gap_ok) begin bad++; $display("FAIL gap_idle got=activity exp=quiet"); end
    px(1'b1, 24'h0000FF);
    px(1'b0, 24'd0);
    total++;
    if (out_valid !== 1'b1 || yuv_out !== 8'h55) begin
      bad++;
      $display("FAIL gap_u0 got=%b/%h exp=1/55", out_valid, yuv_out);
    end
    repeat (4) px(1'b0, 24'd0);
  endtask

  task automatic test_reset_mid();
    logic quiet;
    px(1'b1, 24'hFFFFFF);
    px(1'b1, 24'h000000);
    px(1'b0, 24'd0);
    px(1'b0, 24'd0);
    total++;
    if (out_valid !== 1'b1 || yuv_out !== 8'hFF) begin
      bad++;
      $display("FAIL mid_y0 got=%b/%h exp=1/ff", out_valid, yuv_out);
    end
    apply_reset(1);
    total++;
    if (out_valid !== 1'b0) begin bad++; $display("FAIL mid_reset_valid got=%b exp=0", out_valid); end
    quiet = 1'b1;
    for (int k = 0; k < 6; k++) begin
      px(1'b0, 24'd0);
      if (out_valid !== 1'b0) quiet = 1'b0;
    end
    total++;
    if (!quiet) begin bad++; $display("FAIL mid_quiet got=bytes exp=none"); end
    test_pair("after_reset", 24'h00FF00, 24'h00FF00, 32'h2B951595);
  endtask

  task automatic test_back_to_back();
    logic [31:0] rn;
    int          guard;
    for (int k = 0; k < 2000; k++) begin
      rn = $urandom();
      px(1'b1, rn[23:0]);
      total++;
      if (busy !== m_busy()) begin
        bad++;
        $display("FAIL b2b_busy k=%0d got=%b exp=%b", k, busy, m_busy());
      end
      if (k >= 2) begin
        total++;
        if (out_valid !== 1'b1) begin
          bad++;
          $display("FAIL b2b_valid k=%0d got=%b exp=1", k, out_valid);
        end
      end
    end
    guard = 0;
    while (sb.size() != 0 && guard < 20) begin
      px(1'b0, 24'd0);
      guard++;
    end
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL b2b_drain got=%0d pending exp=0", sb.size());
    end
    px(1'b0, 24'd0);
    total++;
    if (out_valid !== 1'b0) begin bad++; $display("FAIL b2b_idle got=%b exp=0", out_valid); end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    m_st  = 0;
    test_reset();
    test_pair("white_black", 24'hFFFFFF, 24'h000000, 32'h80FF8000);
    test_pair("primaries",   24'hFF0000, 24'h0000FF, 32'h554DFF1D);
    test_pair("green",       24'h00FF00, 24'h00FF00, 32'h2B951595);
    test_gapped();
    test_reset_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
